// File: rtl/tx_framer_if.sv
// Byte stream, DAC sample stream and frame control bundle for tx_framer.
// The framer is the slave side; the DMA/DAC environment is the master side.
interface tx_framer_if;
  logic               i_start;
  logic [7:0]         i_len;
  logic [7:0]         i_data;
  logic               i_data_vld;
  logic               o_data_rdy;
  logic               i_dac_stb;
  logic signed [15:0] o_todac_i;
  logic signed [15:0] o_todac_q;
  logic               o_todac_vld;
  logic               o_busy;
  logic               o_done;
  logic               o_err;

  modport slave (
    input  i_start, i_len, i_data, i_data_vld, i_dac_stb,
    output o_data_rdy, o_todac_i, o_todac_q, o_todac_vld, o_busy, o_done, o_err
  );

  modport master (
    output i_start, i_len, i_data, i_data_vld, i_dac_stb,
    input  o_data_rdy, o_todac_i, o_todac_q, o_todac_vld, o_busy, o_done, o_err
  );
endinterface

// File: rtl/tx_framer.sv
// Frames a byte payload as preamble, QPSK length header, QPSK payload and guard,
// zero-stuffed to SPS samples per symbol and paced by the DAC strobe.
module tx_framer #(
  parameter int                 SPS        = 4,
  parameter logic [31:0]        PREAMBLE   = 32'hF3A5_0C96,
  parameter int                 PRE_SYMS   = 32,
  parameter int                 GUARD_SYMS = 8,
  parameter logic signed [15:0] AMP        = 16'sh2000
) (
  input logic        i_clk,
  input logic        i_rstn,
  tx_framer_if.slave bus
);

  localparam int SW = $clog2(SPS);

  typedef enum logic [2:0] {IDLE, PRE, HDR, PAY, GUARD} state_t;

  state_t             stateQ, stateD;
  logic [SW-1:0]      sampQ, sampD;
  logic [9:0]         symQ, symD;
  logic [7:0]         lenQ, lenD;
  logic [7:0]         shiftQ, shiftD;
  logic [7:0]         pfQ, pfD;
  logic [7:0]         fetchedQ, fetchedD;
  logic               pfVldQ, pfVldD;
  logic               zeroSlotQ, zeroSlotD;
  logic               errQ, errD;
  logic               doneQ, doneD;
  logic               vldQ, vldD;
  logic signed [15:0] outIQ, outID;
  logic signed [15:0] outQQ, outQD;

  logic               dataRdy;
  logic               accept;
  logic               startOk;
  logic               symEnd;
  logic               lastSym;
  logic               byteBoundary;
  logic [9:0]         lastIdx;
  logic [4:0]         preIdx;
  logic               preBit;
  logic [1:0]         pair;
  logic signed [15:0] symI;
  logic signed [15:0] symQv;

  assign dataRdy = ((stateQ == HDR) || (stateQ == PAY)) && !pfVldQ && (fetchedQ < lenQ);
  assign accept  = bus.i_data_vld && dataRdy;
  assign startOk = (stateQ == IDLE) && bus.i_start && (bus.i_len != 8'd0);
  assign symEnd  = bus.i_dac_stb && (sampQ == SW'(SPS - 1)) && (stateQ != IDLE);
  assign lastSym = (symQ == lastIdx);

  // The end of HDR is the boundary into the first payload byte, so an empty
  // prefetch there already counts as an underflow of byte 0.
  assign byteBoundary = symEnd &&
                        (((stateQ == HDR) && lastSym) ||
                         ((stateQ == PAY) && (symQ[1:0] == 2'd3) && !lastSym));

  always_comb begin
    lastIdx = '0;
    case (stateQ)
      PRE:     lastIdx = 10'(PRE_SYMS - 1);
      HDR:     lastIdx = 10'd3;
      PAY:     lastIdx = {lenQ, 2'b00} - 10'd1;
      GUARD:   lastIdx = 10'(GUARD_SYMS - 1);
      default: lastIdx = '0;
    endcase
  end

  always_comb begin
    symI   = '0;
    symQv  = '0;
    pair   = '0;
    preIdx = 5'd31 - symQ[4:0];
    preBit = PREAMBLE[preIdx];
    case (stateQ)
      PRE: begin
        symI  = preBit ? -AMP : AMP;
        symQv = symI;
      end
      HDR: begin
        case (symQ[1:0])
          2'd0:    pair = lenQ[7:6];
          2'd1:    pair = lenQ[5:4];
          2'd2:    pair = lenQ[3:2];
          default: pair = lenQ[1:0];
        endcase
        symI  = pair[1] ? -AMP : AMP;
        symQv = pair[0] ? -AMP : AMP;
      end
      PAY: begin
        if (!zeroSlotQ) begin
          pair  = shiftQ[7:6];
          symI  = pair[1] ? -AMP : AMP;
          symQv = pair[0] ? -AMP : AMP;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    stateD    = stateQ;
    sampD     = sampQ;
    symD      = symQ;
    lenD      = lenQ;
    shiftD    = shiftQ;
    pfD       = pfQ;
    pfVldD    = pfVldQ;
    fetchedD  = fetchedQ;
    zeroSlotD = zeroSlotQ;
    errD      = errQ;
    doneD     = 1'b0;
    vldD      = bus.i_dac_stb;
    outID     = '0;
    outQD     = '0;

    if (bus.i_dac_stb && (sampQ == '0)) begin
      outID = symI;
      outQD = symQv;
    end

    if (stateQ == IDLE) begin
      if (startOk) begin
        stateD    = PRE;
        lenD      = bus.i_len;
        errD      = 1'b0;
        sampD     = '0;
        symD      = '0;
        fetchedD  = '0;
        pfVldD    = 1'b0;
        zeroSlotD = 1'b0;
        shiftD    = '0;
      end
    end else begin
      if (bus.i_dac_stb) begin
        sampD = sampQ + SW'(1);
      end
      if (symEnd) begin
        if (lastSym) begin
          symD = '0;
          case (stateQ)
            PRE:     stateD = HDR;
            HDR:     stateD = PAY;
            PAY:     stateD = GUARD;
            GUARD: begin
              stateD = IDLE;
              doneD  = 1'b1;
            end
            default: stateD = IDLE;
          endcase
        end else begin
          symD = symQ + 10'd1;
        end
      end

      // A byte arriving exactly on an empty-prefetch boundary bypasses the
      // prefetch so it is neither lost nor reported as an underflow.
      if (byteBoundary) begin
        if (pfVldQ) begin
          shiftD    = pfQ;
          pfVldD    = 1'b0;
          zeroSlotD = 1'b0;
        end else if (accept) begin
          shiftD    = bus.i_data;
          zeroSlotD = 1'b0;
        end else begin
          shiftD    = '0;
          zeroSlotD = 1'b1;
          errD      = 1'b1;
        end
      end else begin
        if (symEnd && (stateQ == PAY)) begin
          shiftD = {shiftQ[5:0], 2'b00};
        end
        if (accept) begin
          pfD    = bus.i_data;
          pfVldD = 1'b1;
        end
      end

      if (accept) begin
        fetchedD = fetchedQ + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stateQ    <= IDLE;
      sampQ     <= '0;
      symQ      <= '0;
      lenQ      <= '0;
      shiftQ    <= '0;
      pfQ       <= '0;
      pfVldQ    <= 1'b0;
      fetchedQ  <= '0;
      zeroSlotQ <= 1'b0;
      errQ      <= 1'b0;
      doneQ     <= 1'b0;
      vldQ      <= 1'b0;
      outIQ     <= '0;
      outQQ     <= '0;
    end else begin
      stateQ    <= stateD;
      sampQ     <= sampD;
      symQ      <= symD;
      lenQ      <= lenD;
      shiftQ    <= shiftD;
      pfQ       <= pfD;
      pfVldQ    <= pfVldD;
      fetchedQ  <= fetchedD;
      zeroSlotQ <= zeroSlotD;
      errQ      <= errD;
      doneQ     <= doneD;
      vldQ      <= vldD;
      outIQ     <= outID;
      outQQ     <= outQD;
    end
  end

  assign bus.o_data_rdy  = dataRdy;
  assign bus.o_todac_i   = outIQ;
  assign bus.o_todac_q   = outQQ;
  assign bus.o_todac_vld = vldQ;
  assign bus.o_busy      = (stateQ != IDLE);
  assign bus.o_done      = doneQ;
  assign bus.o_err       = errQ;

endmodule

// File: tb/tb_tx_framer.sv
// Scoreboard bench for tx_framer: a frame-level model queues expected DAC samples,
// a monitor pops and compares them whenever the DUT presents a valid sample.
module tb_tx_framer;
  localparam int          SPS        = 4;
  localparam int          PRE_SYMS   = 32;
  localparam int          GUARD_SYMS = 8;
  localparam logic [31:0] PREAMBLE   = 32'hF3A5_0C96;
  localparam int          AMPV       = 8192;

  typedef struct {
    int i;
    int q;
  } samp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  tx_framer_if bus();

  tx_framer dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  samp_t      expQ[$];
  logic [7:0] dataQ[$];
  logic [7:0] curBytes[$];
  int         nChecks   = 0;
  int         nFails    = 0;
  int         doneCount = 0;
  int         popCount  = 0;
  int         stbMode   = 0;
  bit         holdStb   = 1'b0;
  bit         dataGaps  = 1'b0;
  bit         expErr    = 1'b0;
  bit         stbSeen   = 1'b0;
  bit         rstnSeen  = 1'b0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ampOf(input bit b);
    return b ? -AMPV : AMPV;
  endfunction

  task automatic pushSymbol(input int si, input int sq);
    samp_t s;
    s.i = si;
    s.q = sq;
    expQ.push_back(s);
    s.i = 0;
    s.q = 0;
    for (int k = 1; k < SPS; k++) expQ.push_back(s);
  endtask

  // Expected frame built from the framing rules, symbol by symbol.
  task automatic buildFrame(input int len, input bit underflow);
    logic [31:0] pre;
    logic [7:0]  b;
    int          pr;
    pre = PREAMBLE;
    for (int k = 0; k < PRE_SYMS; k++) pushSymbol(ampOf(pre[31-k]), ampOf(pre[31-k]));
    for (int k = 0; k < 4; k++) begin
      pr = (len >> (6 - 2*k)) & 3;
      pushSymbol(ampOf(pr[1]), ampOf(pr[0]));
    end
    for (int n = 0; n < len; n++) begin
      b = underflow ? 8'h00 : curBytes[n];
      for (int k = 0; k < 4; k++) begin
        pr = (int'(b) >> (6 - 2*k)) & 3;
        if (underflow) pushSymbol(0, 0);
        else           pushSymbol(ampOf(pr[1]), ampOf(pr[0]));
      end
    end
    for (int k = 0; k < GUARD_SYMS; k++) pushSymbol(0, 0);
  endtask

  task automatic applyStimulus(input int len, input bit push, input bit underflow);
    @(posedge clk);
    #1;
    holdStb     = 1'b1;
    bus.i_start = 1'b1;
    bus.i_len   = 8'(len);
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    holdStb     = 1'b0;
    if (push) begin
      expErr = underflow;
      buildFrame(len, underflow);
    end
  endtask

  task automatic waitDone(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.o_done) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
    checkOutput("doneSeen", seen, 1);
  endtask

  task automatic waitExpBelow(input int n, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (expQ.size() <= n) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("reachPoint", ok, 1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, bus.o_busy, 0);
    checkOutput({tag, "_done"}, bus.o_done, 0);
    checkOutput({tag, "_err"},  bus.o_err, 0);
    checkOutput({tag, "_rdy"},  bus.o_data_rdy, 0);
    checkOutput({tag, "_vld"},  bus.o_todac_vld, 0);
    checkOutput({tag, "_i"},    bus.o_todac_i, 0);
    checkOutput({tag, "_q"},    bus.o_todac_q, 0);
  endtask

  initial begin
    int cnt;
    cnt           = 0;
    bus.i_dac_stb = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (holdStb)           bus.i_dac_stb = 1'b0;
      else if (stbMode == 0) bus.i_dac_stb = 1'b1;
      else if (stbMode == 1) bus.i_dac_stb = ((cnt % 3) == 0);
      else                   bus.i_dac_stb = 1'($urandom_range(0, 1));
      cnt++;
    end
  end

  initial begin
    bit acc;
    int gap;
    gap            = 0;
    bus.i_data     = '0;
    bus.i_data_vld = 1'b0;
    forever begin
      @(negedge clk);
      acc = bus.i_data_vld && bus.o_data_rdy;
      @(posedge clk);
      #1;
      if (acc && dataQ.size() > 0) void'(dataQ.pop_front());
      if (dataQ.size() > 0 && (!dataGaps || gap >= 4 || $urandom_range(0, 1) == 1)) begin
        bus.i_data_vld = 1'b1;
        bus.i_data     = dataQ[0];
        gap            = 0;
      end else begin
        bus.i_data_vld = 1'b0;
        gap++;
      end
    end
  end

  initial begin
    samp_t e;
    forever begin
      @(negedge clk);
      if (rstn && rstnSeen) begin
        checkOutput("vldAfterStb", bus.o_todac_vld, stbSeen);
        if (bus.o_todac_vld) begin
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
            popCount++;
            checkOutput("sampleI", longint'($signed(bus.o_todac_i)), e.i);
            checkOutput("sampleQ", longint'($signed(bus.o_todac_q)), e.q);
          end else begin
            checkOutput("idleI", longint'($signed(bus.o_todac_i)), 0);
            checkOutput("idleQ", longint'($signed(bus.o_todac_q)), 0);
          end
        end
        if (bus.o_done) begin
          doneCount++;
          checkOutput("frameLen", expQ.size(), 0);
          checkOutput("errAtDone", bus.o_err, expErr);
        end
      end
      rstnSeen = rstn;
      stbSeen  = rstn ? bus.i_dac_stb : 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d0;
    int p0;
    int len;
    bus.i_start = 1'b0;
    bus.i_len   = '0;

    repeat (2) @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #3;
    rstn = 1'b1;
    @(negedge clk);
    checkAllZero("afterReset");

    $display("[TB] frame len=2, strobe every cycle");
    stbMode  = 0;
    dataGaps = 1'b0;
    curBytes = '{8'h1B, 8'hE4};
    dataQ    = '{8'h1B, 8'hE4};
    d0 = doneCount;
    p0 = popCount;
    applyStimulus(2, 1'b1, 1'b0);
    waitDone(600);
    checkOutput("doneCountA", doneCount, d0 + 1);
    checkOutput("samplesA", popCount - p0, 208);

    $display("[TB] same frame, strobe every third cycle");
    stbMode = 1;
    dataQ   = '{8'h1B, 8'hE4};
    d0 = doneCount;
    p0 = popCount;
    applyStimulus(2, 1'b1, 1'b0);
    waitDone(1500);
    checkOutput("doneCountB", doneCount, d0 + 1);
    checkOutput("samplesB", popCount - p0, 208);

    $display("[TB] underflow frame len=1");
    stbMode  = 0;
    curBytes = '{8'h00};
    p0 = popCount;
    applyStimulus(1, 1'b1, 1'b1);
    waitDone(600);
    checkOutput("samplesUnderflow", popCount - p0, 192);
    repeat (3) @(negedge clk);
    checkOutput("errSticky", bus.o_err, 1);

    $display("[TB] zero-length start");
    d0 = doneCount;
    applyStimulus(0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("len0Busy", bus.o_busy, 0);
      checkOutput("len0Rdy", bus.o_data_rdy, 0);
    end
    checkOutput("len0Done", doneCount, d0);
    checkOutput("len0ErrKept", bus.o_err, 1);

    $display("[TB] start re-pulse during guard, back-to-back frame");
    curBytes = '{8'h5A, 8'hC3, 8'h0F};
    dataQ    = '{8'h5A, 8'hC3, 8'h0F};
    d0 = doneCount;
    applyStimulus(3, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("errCleared", bus.o_err, 0);
    checkOutput("busyAfterStart", bus.o_busy, 1);
    waitExpBelow(GUARD_SYMS*SPS - 4, 600);
    applyStimulus(5, 1'b0, 1'b0);
    waitDone(300);
    checkOutput("singleDone", doneCount, d0 + 1);
    curBytes = '{8'h96, 8'h3C};
    dataQ    = '{8'h96, 8'h3C};
    stbMode  = 2;
    applyStimulus(2, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("backToBackBusy", bus.o_busy, 1);
    waitDone(2000);
    checkOutput("doneCountE", doneCount, d0 + 2);

    $display("[TB] reset in the middle of the payload");
    stbMode  = 0;
    curBytes = '{8'hA5, 8'h5A, 8'hFF};
    dataQ    = '{8'hA5, 8'h5A, 8'hFF};
    applyStimulus(3, 1'b1, 1'b0);
    waitExpBelow((4*3 + GUARD_SYMS)*SPS - 8, 600);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    checkAllZero("midReset");
    expQ.delete();
    dataQ.delete();
    repeat (3) @(posedge clk);
    #3;
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("postResetBusy", bus.o_busy, 0);
      checkOutput("postResetDone", bus.o_done, 0);
    end

    $display("[TB] randomized frames");
    dataGaps = 1'b1;
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 12);
      curBytes.delete();
      dataQ.delete();
      for (int n = 0; n < len; n++) begin
        curBytes.push_back(8'($urandom));
        dataQ.push_back(curBytes[n]);
      end
      stbMode = $urandom_range(0, 2);
      d0 = doneCount;
      p0 = popCount;
      applyStimulus(len, 1'b1, 1'b0);
      waitDone(6000);
      checkOutput("randDone", doneCount, d0 + 1);
      checkOutput("randSamples", popCount - p0, (PRE_SYMS + 4 + 4*len + GUARD_SYMS)*SPS);
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
